// File: rtl/ascon_pkg.sv
// Shared types for the Ascon streaming front end: modes, segment tags,
// sequencer states and error codes.
package ascon_pkg;

   typedef enum logic [2:0] {
      MODE_AEAD128_ENC = 3'd0,
      MODE_AEAD128_DEC = 3'd1,
      MODE_HASH256     = 3'd2,
      MODE_XOF128      = 3'd3
   } ascon_mode_t;

   typedef enum logic [2:0] {
      TUSER_KEY   = 3'd0,
      TUSER_NONCE = 3'd1,
      TUSER_AD    = 3'd2,
      TUSER_PT    = 3'd3,
      TUSER_CT    = 3'd4,
      TUSER_MSG   = 3'd5,
      TUSER_TAG   = 3'd6
   } axi_tuser_t;

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_NONCE, S_AD, S_DATA, S_TAG, S_FLUSH, S_DRAIN
   } seq_state_t;

   localparam logic [2:0] SEQ_ERR_NONE  = 3'd0;
   localparam logic [2:0] SEQ_ERR_TUSER = 3'd1;
   localparam logic [2:0] SEQ_ERR_SHORT = 3'd2;
   localparam logic [2:0] SEQ_ERR_LONG  = 3'd3;
   localparam logic [2:0] SEQ_ERR_MODE  = 3'd4;

   // Payload segment tag expected for each mode.
   function automatic axi_tuser_t data_tuser(ascon_mode_t m);
      case (m)
         MODE_AEAD128_ENC: return TUSER_PT;
         MODE_AEAD128_DEC: return TUSER_CT;
         default:          return TUSER_MSG;
      endcase
   endfunction

endpackage

// File: rtl/ascon_stream_sequencer_if.sv
// 64-bit AXI4-Stream bundle carrying a segment tag in tuser.
interface ascon_stream_sequencer_if;
   logic [63:0]            tdata;
   logic [7:0]             tkeep;
   ascon_pkg::axi_tuser_t  tuser;
   logic                   tlast;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/ascon_axis_reg.sv
// Single-entry registered AXIS stage; the held beat stays put while the
// consumer stalls.
module ascon_axis_reg
   import ascon_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [63:0]                      in_data,
   input  logic [7:0]                       in_keep,
   input  axi_tuser_t                       in_user,
   input  logic                             in_last,
   ascon_stream_sequencer_if.master         m
);

   assign in_ready = !m.tvalid || m.tready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m.tvalid <= 1'b0;
         m.tdata  <= '0;
         m.tkeep  <= '0;
         m.tuser  <= TUSER_KEY;
         m.tlast  <= 1'b0;
      end else if (in_valid && in_ready) begin
         m.tvalid <= 1'b1;
         m.tdata  <= in_data;
         m.tkeep  <= in_keep;
         m.tuser  <= in_user;
         m.tlast  <= in_last;
      end else if (m.tready) begin
         m.tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/ascon_stream_sequencer.sv
// Command-driven segment sequencer in front of ascon_padder: checks segment
// order and fixed lengths, drops empty AD and drains malformed packets.
module ascon_stream_sequencer
   import ascon_pkg::*;
#(
   parameter int KEY_WORDS   = 2,
   parameter int NONCE_WORDS = 2,
   parameter int TAG_WORDS   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  ascon_mode_t               cmd_mode,
   output ascon_mode_t               mode_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [2:0]                err_code_o,
   ascon_stream_sequencer_if.slave   s_axis,
   ascon_stream_sequencer_if.master  m_axis
);

   localparam logic [1:0] KEY_LAST   = 2'(KEY_WORDS - 1);
   localparam logic [1:0] NONCE_LAST = 2'(NONCE_WORDS - 1);
   localparam logic [1:0] TAG_LAST   = 2'(TAG_WORDS - 1);

   seq_state_t state, nxt_seg;
   axi_tuser_t exp_user;
   logic [1:0] cnt, last_idx;
   logic       fixed, space, acc, active, drop_ad, fwd;
   logic [2:0] code;

   always_comb begin
      exp_user = TUSER_KEY;
      last_idx = KEY_LAST;
      fixed    = 1'b0;
      nxt_seg  = S_FLUSH;
      case (state)
         S_KEY:   begin fixed = 1'b1; nxt_seg = S_NONCE; end
         S_NONCE: begin exp_user = TUSER_NONCE; last_idx = NONCE_LAST; fixed = 1'b1; nxt_seg = S_AD; end
         S_AD:    begin exp_user = TUSER_AD; nxt_seg = S_DATA; end
         S_DATA:  begin
            exp_user = data_tuser(mode_o);
            nxt_seg  = (mode_o == MODE_AEAD128_DEC) ? S_TAG : S_FLUSH;
         end
         S_TAG:   begin exp_user = TUSER_TAG; last_idx = TAG_LAST; fixed = 1'b1; end
         default: ;
      endcase
   end

   // Tag mismatch wins over length problems on the same beat.
   always_comb begin
      code = SEQ_ERR_NONE;
      if (s_axis.tuser != exp_user)                    code = SEQ_ERR_TUSER;
      else if (fixed && s_axis.tlast && cnt != last_idx)  code = SEQ_ERR_SHORT;
      else if (fixed && !s_axis.tlast && cnt == last_idx) code = SEQ_ERR_LONG;
   end

   assign active    = state inside {S_KEY, S_NONCE, S_AD, S_DATA, S_TAG};
   assign cmd_ready = (state == S_IDLE);
   assign s_axis.tready = (state == S_DRAIN) || (active && space);
   assign acc     = s_axis.tvalid && s_axis.tready;
   assign drop_ad = (state == S_AD) && (cnt == 2'd0) && s_axis.tlast && (s_axis.tkeep == 8'h00);
   assign fwd     = acc && active && (code == SEQ_ERR_NONE) && !drop_ad;

   ascon_axis_reg u_oreg (
      .clk      (clk),
      .rst      (rst),
      .in_valid (fwd),
      .in_ready (space),
      .in_data  (s_axis.tdata),
      .in_keep  (s_axis.tkeep),
      .in_user  (s_axis.tuser),
      .in_last  (s_axis.tlast),
      .m        (m_axis)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         mode_o     <= MODE_HASH256;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= SEQ_ERR_NONE;
         cnt        <= 2'd0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: if (cmd_valid) begin
               mode_o     <= cmd_mode;
               err_o      <= 1'b0;
               err_code_o <= SEQ_ERR_NONE;
               cnt        <= 2'd0;
               case (cmd_mode)
                  MODE_AEAD128_ENC, MODE_AEAD128_DEC: begin state <= S_KEY;  busy_o <= 1'b1; end
                  MODE_HASH256, MODE_XOF128:          begin state <= S_DATA; busy_o <= 1'b1; end
                  default: begin err_o <= 1'b1; err_code_o <= SEQ_ERR_MODE; end
               endcase
            end
            // Error paths reach FLUSH with err_o already set, so no done pulse.
            S_FLUSH: if (!m_axis.tvalid) begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
               done_o <= !err_o;
            end
            S_DRAIN: if (acc && s_axis.tlast) state <= S_FLUSH;
            default: if (acc) begin
               if (code != SEQ_ERR_NONE) begin
                  err_o <= 1'b1;
                  if (err_code_o == SEQ_ERR_NONE) err_code_o <= code;
                  state <= s_axis.tlast ? S_FLUSH : S_DRAIN;
               end else if (s_axis.tlast) begin
                  cnt   <= 2'd0;
                  state <= nxt_seg;
               end else if (cnt != 2'd3) begin
                  cnt <= cnt + 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_stream_sequencer.sv
// Scoreboard bench: a packet-level model predicts forwarded beats and the
// outcome of each operation; a monitor checks every m_axis handshake.
module tb_ascon_stream_sequencer;
   import ascon_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0;
   ascon_mode_t cmd_mode  = MODE_HASH256;
   logic        cmd_ready, busy_o, done_o, err_o;
   ascon_mode_t mode_o;
   logic [2:0]  err_code_o;

   ascon_stream_sequencer_if s_if ();
   ascon_stream_sequencer_if m_if ();

   ascon_stream_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .mode_o     (mode_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .err_code_o (err_code_o),
      .s_axis     (s_if),
      .m_axis     (m_if)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      axi_tuser_t  u;
      logic        l;
   } beat_t;

   typedef struct {
      axi_tuser_t u;
      int         len;
      logic [7:0] lk;
   } pkt_t;

   beat_t exp_q[$];
   pkt_t  pkts[$];
   int    n_cmp = 0, n_bad = 0, done_cnt = 0;
   int    rdy_mode = 2;  // 0 stall, 1 random, 2 always ready, 3 toggle

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_if.tready = 1'b0;
         1: m_if.tready = 1'($urandom_range(0, 1));
         3: m_if.tready = ~m_if.tready;
         default: m_if.tready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      beat_t b;
      if (done_o) done_cnt++;
      if (rst && m_if.tvalid && m_if.tready) begin
         if (exp_q.size() == 0) chk("unexpected_m_beat", 64'(exp_q.size()), 64'd1);
         else begin
            b = exp_q.pop_front();
            chk("m_tdata", m_if.tdata, b.d);
            chk("m_tkeep", 64'(m_if.tkeep), 64'(b.k));
            chk("m_tuser", 64'(m_if.tuser), 64'(b.u));
            chk("m_tlast", 64'(m_if.tlast), 64'(b.l));
         end
      end
   end

   function automatic beat_t mk_beat(axi_tuser_t u, logic l, logic [7:0] k);
      beat_t b;
      b.d = {$urandom, $urandom};
      b.k = k;
      b.u = u;
      b.l = l;
      return b;
   endfunction

   task automatic send_beat(beat_t b);
      int t = 0;
      if ($urandom_range(0, 3) == 0)
         repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      s_if.tdata  = b.d;
      s_if.tkeep  = b.k;
      s_if.tuser  = b.u;
      s_if.tlast  = b.l;
      s_if.tvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!s_if.tready && t < 300);
      if (!s_if.tready) chk("s_tready_timeout", 64'(s_if.tready), 64'd1);
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic issue_cmd(ascon_mode_t m);
      int t = 0;
      while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
      if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = m;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Reference: walk packets against the mode's segment list.
   task automatic run_op(ascon_mode_t mode);
      beat_t      bl[$];
      axi_tuser_t segs[$];
      int err = 0, nsend = 0, off = 0, d0, t;
      foreach (pkts[p])
         for (int i = 0; i < pkts[p].len; i++)
            bl.push_back(mk_beat(pkts[p].u, i == pkts[p].len - 1,
                                 (i == pkts[p].len - 1) ? pkts[p].lk : 8'hFF));
      case (mode)
         MODE_AEAD128_ENC: segs = '{TUSER_KEY, TUSER_NONCE, TUSER_AD, TUSER_PT};
         MODE_AEAD128_DEC: segs = '{TUSER_KEY, TUSER_NONCE, TUSER_AD, TUSER_CT, TUSER_TAG};
         MODE_HASH256, MODE_XOF128: segs = '{TUSER_MSG};
         default: err = 4;
      endcase
      for (int p = 0; p < pkts.size() && p < segs.size() && err == 0; p++) begin
         int len = pkts[p].len, nfwd = pkts[p].len, need = 0;
         if (segs[p] == TUSER_KEY || segs[p] == TUSER_NONCE || segs[p] == TUSER_TAG) need = 2;
         nsend += len;
         if (pkts[p].u != segs[p]) begin err = 1; nfwd = 0; end
         else if (need != 0 && len < need) begin err = 2; nfwd = len - 1; end
         else if (need != 0 && len > need) begin err = 3; nfwd = need - 1; end
         else if (segs[p] == TUSER_AD && len == 1 && pkts[p].lk == 8'h00) nfwd = 0;
         for (int i = 0; i < nfwd; i++) exp_q.push_back(bl[off + i]);
         off += len;
      end
      d0 = done_cnt;
      issue_cmd(mode);
      chk("mode_o", 64'(mode_o), 64'(mode));
      chk("busy_after_cmd", 64'(busy_o), (err == 4) ? 64'd0 : 64'd1);
      for (int i = 0; i < nsend; i++) send_beat(bl[i]);
      t = 0;
      while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
      chk("op_back_to_idle", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      chk("done_pulses", 64'(done_cnt - d0), (err == 0) ? 64'd1 : 64'd0);
      chk("err_o", 64'(err_o), (err != 0) ? 64'd1 : 64'd0);
      chk("err_code", 64'(err_code_o), 64'(err));
      chk("beats_left", 64'(exp_q.size()), 64'd0);
      chk("busy_idle", 64'(busy_o), 64'd0);
      exp_q.delete();
   endtask

   function automatic pkt_t mkp(axi_tuser_t u, int len, logic [7:0] lk);
      pkt_t p;
      p.u = u; p.len = len; p.lk = lk;
      return p;
   endfunction

   initial begin
      ascon_mode_t m;
      beat_t       b;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tuser  = TUSER_KEY;
      s_if.tlast  = 1'b0;
      #12;
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_if.tready), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_err_code", 64'(err_code_o), 64'd0);
      chk("rst_mode", 64'(mode_o), 64'(MODE_HASH256));
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);

      // Encrypt with 2-word AD and 3-word PT.
      pkts = '{mkp(TUSER_KEY, 2, 8'hFF), mkp(TUSER_NONCE, 2, 8'hFF),
               mkp(TUSER_AD, 2, 8'hFF), mkp(TUSER_PT, 3, 8'h0F)};
      run_op(MODE_AEAD128_ENC);
      // Decrypt, empty AD, toggling downstream ready.
      rdy_mode = 3;
      pkts = '{mkp(TUSER_KEY, 2, 8'hFF), mkp(TUSER_NONCE, 2, 8'hFF),
               mkp(TUSER_AD, 1, 8'h00), mkp(TUSER_CT, 1, 8'h3F), mkp(TUSER_TAG, 2, 8'hFF)};
      run_op(MODE_AEAD128_DEC);
      rdy_mode = 2;
      pkts = '{mkp(TUSER_MSG, 1, 8'h01)};
      run_op(MODE_HASH256);
      pkts = '{mkp(TUSER_KEY, 1, 8'hFF)};
      run_op(MODE_AEAD128_ENC);
      pkts = '{mkp(TUSER_KEY, 2, 8'hFF), mkp(TUSER_PT, 4, 8'hFF)};
      run_op(MODE_AEAD128_ENC);
      pkts = '{mkp(TUSER_MSG, 1, 8'h00)};
      run_op(MODE_XOF128);
      pkts = '{};
      run_op(ascon_mode_t'(3'd5));

      // Abort mid-AD with a beat stuck in the output register.
      issue_cmd(MODE_AEAD128_ENC);
      for (int i = 0; i < 4; i++) begin
         b = mk_beat((i < 2) ? TUSER_KEY : TUSER_NONCE, i[0], 8'hFF);
         exp_q.push_back(b);
         send_beat(b);
      end
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      send_beat(mk_beat(TUSER_AD, 1'b0, 8'hFF));
      chk("pre_rst_m_tvalid", 64'(m_if.tvalid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("abort_busy", 64'(busy_o), 64'd0);
      chk("abort_s_tready", 64'(s_if.tready), 64'd0);
      exp_q.delete();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // Randomized operations with occasional corrupted tags and lengths.
      rdy_mode = 1;
      for (int n = 0; n < 40; n++) begin
         axi_tuser_t segs[$];
         int r = $urandom_range(0, 12);
         m = (r == 12) ? ascon_mode_t'(3'd6) : ascon_mode_t'(3'(r % 4));
         case (m)
            MODE_AEAD128_ENC: segs = '{TUSER_KEY, TUSER_NONCE, TUSER_AD, TUSER_PT};
            MODE_AEAD128_DEC: segs = '{TUSER_KEY, TUSER_NONCE, TUSER_AD, TUSER_CT, TUSER_TAG};
            MODE_HASH256, MODE_XOF128: segs = '{TUSER_MSG};
            default: segs = '{};
         endcase
         pkts = '{};
         foreach (segs[s]) begin
            pkt_t p;
            int   c = $urandom_range(0, 19);
            p.u  = segs[s];
            p.lk = 8'($urandom);
            if (segs[s] == TUSER_KEY || segs[s] == TUSER_NONCE || segs[s] == TUSER_TAG) begin
               p.len = 2;
               if (c == 1) p.len = $urandom_range(0, 1) ? 1 : 3;
            end else if (segs[s] == TUSER_AD) begin
               p.len = $urandom_range(0, 3);
               if (p.len == 0) begin p.len = 1; p.lk = 8'h00; end
            end else p.len = $urandom_range(1, 4);
            if (c == 0) p.u = axi_tuser_t'(3'((int'(segs[s]) + 1 + $urandom_range(0, 5)) % 7));
            pkts.push_back(p);
         end
         run_op(m);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
